wave_analyzer: RTL
==================

WAVE_ANALYZER -- requirements
Module: wave_analyzer

Interface
REQ-001 Parameter WAVE_W, default 8, sample width in bits.
REQ-002 Parameter PERIOD_W, default 16, period counter width in bits.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_valid  input  1  sample accepted on the clk edge where high.
REQ-006 sample  input  WAVE_W  unsigned waveform sample from the generator.
REQ-007 clear  input  1  synchronous measurement restart; same effect as rst on all state.
REQ-008 dir  output  1  current slope: 0 rising, 1 falling.
REQ-009 peak_max  output  WAVE_W  value of the most recent maximum turning point.
REQ-010 peak_min  output  WAVE_W  value of the most recent minimum turning point.
REQ-011 amplitude  output  WAVE_W  peak_max minus peak_min, captured at each maximum event.
REQ-012 period  output  PERIOD_W  accepted samples between successive maximum events.
REQ-013 meas_valid  output  1  one-cycle pulse: peak_max, peak_min, amplitude, period just updated.
REQ-014 locked  output  1  at least one complete period measured since the last reset, clear or timeout.

Function
REQ-015 The FSM SHALL have states IDLE (no sample held), RISE and FALL; dir = 1 only in FALL.
REQ-016 In IDLE, the first accepted sample SHALL be stored as prev, and the FSM SHALL enter RISE.
REQ-017 Each accepted sample SHALL be compared with prev and then stored as prev.
REQ-018 Sample equal to prev: no state change and no event.
REQ-019 RISE, sample < prev: maximum event; peak_max <= prev; enter FALL.
REQ-020 RISE, sample > prev: stay in RISE.
REQ-021 FALL, sample > prev: minimum event; peak_min <= prev; enter RISE.
REQ-022 FALL, sample < prev: stay in FALL.
REQ-023 The sample counter SHALL increment on every accepted sample that is not a maximum event.
REQ-024 The sample counter SHALL saturate at 2^PERIOD_W-1.
REQ-025 On a maximum event, the counter SHALL reset to 0.
REQ-026 On a maximum event with a prior maximum and a prior minimum since restart, the block SHALL capture period <= counter+1 and amplitude <= prev - peak_min.
REQ-027 On the edge after the REQ-026 captures, meas_valid SHALL be 1 for exactly one cycle, and locked SHALL set.
REQ-028 The first maximum event after restart SHALL update peak_max only, with no meas_valid.
REQ-029 Counter saturation SHALL clear locked and discard the prior-maximum flag.
REQ-030 After saturation, the next maximum event SHALL behave as the first (REQ-028).
REQ-031 Cycles with sample_valid = 0 SHALL change nothing except dropping meas_valid.
REQ-032 clear and rst SHALL have priority over a simultaneously accepted sample; that sample is discarded.

Reset
REQ-033 On rst or clear: FSM = IDLE, prev = 0, counter = 0, all flags cleared.
REQ-034 On rst or clear, the outputs SHALL be: dir = 0, peak_max = 0, peak_min = 0, amplitude = 0, period = 0, meas_valid = 0, locked = 0.
REQ-035 rst or clear asserted mid-period SHALL abandon the partial measurement; no meas_valid is produced from it.

Structure
REQ-036 Shared package wave_pkg SHALL hold WAVE_W/PERIOD_W defaults and the state encoding (IDLE, RISE, FALL).
REQ-037 The generator SHALL import wave_pkg.
REQ-038 Turning-point detection (prev register, compare, FSM) SHALL be sub-module wave_turn_detect, which emits max_evt/min_evt/turn_value.
REQ-039 The top level SHALL hold the counter, capture registers and output logic.

Verification
REQ-040 Continuous 0..255..0 triangle, one sample per clk -> meas_valid every 510 samples from the 2nd maximum on; period = 510, peak_max = 255, peak_min = 0, amplitude = 255.
REQ-041 Triangle 10..20..10 -> period = 20, peak_max = 20, peak_min = 10, amplitude = 10; locked = 1 after the first meas_valid.
REQ-042 Same 10..20 triangle with sample_valid low on every other cycle -> period = 20, unchanged.
REQ-043 Constant sample 128 for 70000 accepted samples -> no meas_valid; locked = 0; counter held at 65535.
REQ-044 Constant sample, then triangle 0..255 -> the first maximum gives no meas_valid, the second gives period = 510.
REQ-045 clear pulsed mid-fall of the 0..255 triangle -> all outputs = 0 next cycle; the first meas_valid appears only at the second maximum after clear.
REQ-046 rst asserted on the same edge as a maximum event -> no meas_valid; all outputs = 0 next cycle.

Source files
------------

// File: rtl/wave_pkg.sv
// Shared definitions for the waveform analyzer: default widths, turning-point
// FSM encoding and a saturating-increment helper.
package wave_pkg;

  localparam int WAVE_W_DEF   = 8;
  localparam int PERIOD_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_FALL = 2'd2
  } turn_state_e;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [PERIOD_W_DEF-1:0] sat_inc16(input logic [PERIOD_W_DEF-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wave_turn_detect.sv
// Turning-point detector: holds the previous accepted sample, tracks the slope
// and flags maxima/minima combinationally on the accepting edge.
module wave_turn_detect
  import wave_pkg::*;
#(
  parameter int WAVE_W = WAVE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [WAVE_W-1:0] sample,
  output logic              dir,
  output logic              max_evt,
  output logic              min_evt,
  output logic [WAVE_W-1:0] turn_value
);

  turn_state_e       state_q, state_d;
  logic [WAVE_W-1:0] prev_q, prev_d;
  logic              dir_q, dir_d;

  // Events are suppressed while rst is high so a restart wins over the sample.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    max_evt = 1'b0;
    min_evt = 1'b0;
    if (sample_valid && !rst) begin
      prev_d = sample;
      case (state_q)
        ST_IDLE: state_d = ST_RISE;
        ST_RISE: begin
          if (sample < prev_q) begin
            max_evt = 1'b1;
            state_d = ST_FALL;
          end
        end
        ST_FALL: begin
          if (sample > prev_q) begin
            min_evt = 1'b1;
            state_d = ST_RISE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    dir_d = (state_d == ST_FALL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      dir_q   <= dir_d;
    end
  end

  assign dir        = dir_q;
  assign turn_value = prev_q;

endmodule

// File: rtl/wave_analyzer.sv
// Waveform analyzer top: counts samples between maxima and captures peak,
// amplitude and period measurements from the turning-point detector.
module wave_analyzer
  import wave_pkg::*;
#(
  parameter int WAVE_W   = WAVE_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [WAVE_W-1:0]   sample,
  input  logic                clear,
  output logic                dir,
  output logic [WAVE_W-1:0]   peak_max,
  output logic [WAVE_W-1:0]   peak_min,
  output logic [WAVE_W-1:0]   amplitude,
  output logic [PERIOD_W-1:0] period,
  output logic                meas_valid,
  output logic                locked
);

  localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

  logic              restart;
  logic              accept;
  logic              max_evt;
  logic              min_evt;
  logic [WAVE_W-1:0] turn_value;

  logic [PERIOD_W-1:0] counter_q, counter_d;
  logic                have_max_q, have_max_d;
  logic                have_min_q, have_min_d;
  logic [WAVE_W-1:0]   peak_max_q, peak_max_d;
  logic [WAVE_W-1:0]   peak_min_q, peak_min_d;
  logic [WAVE_W-1:0]   amplitude_q, amplitude_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                meas_valid_q, meas_valid_d;
  logic                locked_q, locked_d;

  assign restart = rst | clear;
  assign accept  = sample_valid & ~restart;

  wave_turn_detect #(
    .WAVE_W(WAVE_W)
  ) u_turn (
    .clk         (clk),
    .rst         (restart),
    .sample_valid(sample_valid),
    .sample      (sample),
    .dir         (dir),
    .max_evt     (max_evt),
    .min_evt     (min_evt),
    .turn_value  (turn_value)
  );

  always_comb begin
    counter_d    = counter_q;
    have_max_d   = have_max_q;
    have_min_d   = have_min_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    amplitude_d  = amplitude_q;
    period_d     = period_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    if (accept) begin
      if (max_evt) begin
        counter_d  = '0;
        peak_max_d = turn_value;
        have_max_d = 1'b1;
        // A full period needs an earlier maximum and a minimum in between.
        if (have_max_q && have_min_q) begin
          period_d     = counter_q + 1'b1;
          amplitude_d  = turn_value - peak_min_q;
          meas_valid_d = 1'b1;
          locked_d     = 1'b1;
        end
      end else begin
        if (counter_q != CNT_MAX) begin
          counter_d = counter_q + 1'b1;
        end
        // Once the count can no longer be trusted, start over from scratch.
        if (counter_d == CNT_MAX) begin
          have_max_d = 1'b0;
          locked_d   = 1'b0;
        end
      end
      if (min_evt) begin
        peak_min_d = turn_value;
        have_min_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      counter_q    <= '0;
      have_max_q   <= 1'b0;
      have_min_q   <= 1'b0;
      peak_max_q   <= '0;
      peak_min_q   <= '0;
      amplitude_q  <= '0;
      period_q     <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      have_max_q   <= have_max_d;
      have_min_q   <= have_min_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      amplitude_q  <= amplitude_d;
      period_q     <= period_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
    end
  end

  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
  assign amplitude  = amplitude_q;
  assign period     = period_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;

endmodule
